// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit : instruction prefetch stage
//
// Issues sequential word fetches to the instruction memory port, buffers the
// in-order responses together with their PC in a DEPTH-entry FIFO, and hands
// them to the core over a valid/ready handshake. A redirect (branch, jump,
// trap) flushes the FIFO, discards responses that are still in flight and
// restarts fetching at redirect_pc.
//
// Optional feature (macro FETCH_MISALIGN_CHK_EN):
//   defined   : a redirect to a non-word-aligned PC sets misalign_err (sticky
//               until reset) and stops further requests; the flush still
//               happens.
//   undefined : misalign_err is absent and redirect_pc[1:0] are forced to 0.
//
// Parameters:
//   DEPTH    FIFO entries and maximum outstanding requests (power of two, >=2)
//   RESET_PC first fetch address after reset
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   mem_req, mem_addr   fetch request and word address
//   mem_gnt             memory accepts the request this cycle
//   mem_rvalid/rdata    in-order response, one per grant
//   instr_valid/instr/instr_pc  FIFO head presented to the core
//   instr_ready         core consumes the head this cycle
//   redirect/redirect_pc  flush and restart at redirect_pc
//   misalign_err        sticky misaligned-redirect flag (optional)
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [31:0]        resp_pc;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   discard;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Buffer storage carries no reset; only the pointers and counters do.
  logic [31:0]        fifo_instr [DEPTH];
  logic [31:0]        fifo_pc    [DEPTH];

  logic [31:0]        redir_pc_eff;
  logic               halt;
  logic [CNT_W:0]     inflight;
  logic               grant;
  logic               rsp;
  logic               push;
  logic               pop;
  logic [CNT_W-1:0]   out_next;
  logic [CNT_W-1:0]   discard_next;

`ifdef FETCH_MISALIGN_CHK_EN
  assign redir_pc_eff = redirect_pc;
  assign halt         = misalign_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_err <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign redir_pc_eff = redirect_pc & 32'hFFFF_FFFC;
  assign halt         = 1'b0;
`endif

  // Every issued request reserves a FIFO slot, so the buffer cannot overflow.
  assign inflight = {1'b0, count} + {1'b0, outstanding};
  assign mem_req  = (state != IDLE) && !halt && (inflight < DEPTH_L);
  assign mem_addr = fetch_pc;

  assign grant = mem_req && mem_gnt;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp   = mem_rvalid && (outstanding != '0);
  // Redirect wins over any same-cycle push or pop.
  assign push  = rsp && (discard == '0) && !redirect;
  assign pop   = instr_valid && instr_ready && !redirect;

  always_comb begin
    out_next = outstanding;
    if (grant) out_next = out_next + CNT_W'(1);
    if (rsp)   out_next = out_next - CNT_W'(1);
  end

  always_comb begin
    discard_next = discard;
    if (rsp && (discard != '0)) discard_next = discard - CNT_W'(1);
  end

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_instr[rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect) begin
        // Everything still in flight after this cycle (including a grant
        // taken now, excluding a response arriving now) must be dropped.
        fetch_pc <= redir_pc_eff;
        resp_pc  <= redir_pc_eff;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        discard  <= out_next;
        state    <= (out_next != '0) ? FLUSH : RUN;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        discard <= discard_next;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
        case (state)
          IDLE:    state <= RUN;
          RUN:     state <= RUN;
          FLUSH:   state <= (discard_next == '0) ? RUN : FLUSH;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= mem_rdata;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && mem_rvalid) begin
      assert (outstanding != '0)
        else $error("fetch_unit: response received with no outstanding request");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit : directed self-checking bench for fetch_unit.
// A small in-order memory model answers grants one cycle later when auto_rsp
// is set; responses can be held back by clearing auto_rsp. Outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        misalign_err;
`endif

  int checks = 0;
  int errors = 0;
  int grants = 0;

  logic        gnt_en;
  logic        auto_rsp;
  logic [31:0] q[$];

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
  endtask

  // One clock cycle: drive memory-side inputs, let the DUT sample, update model.
  task automatic step();
    logic        g;
    logic        rv;
    logic [31:0] a;
    mem_gnt    = gnt_en;
    rv         = auto_rsp && (q.size() > 0);
    mem_rvalid = rv;
    mem_rdata  = rv ? data_of(q[0]) : 32'h0;
    g          = mem_req && gnt_en;
    a          = mem_addr;
    @(posedge clk);
    #1;
    if (rv) void'(q.pop_front());
    if (g) begin
      q.push_back(a);
      grants++;
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    redirect   = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    gnt_en      = 1'b0;
    auto_rsp    = 1'b0;
    mem_gnt     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 32'h0;

    // ---- Reset state (cycle 1, IDLE) ----
    do_reset();
    chk("rst_req",   32'(mem_req),     32'd0);
    chk("rst_addr",  mem_addr,         32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr,            32'h0);
    chk("rst_pc",    instr_pc,         32'h0);

    // ---- Free-running stream ----
    gnt_en = 1'b1; auto_rsp = 1'b1; instr_ready = 1'b1;
    step();
    chk("t1_req_c2",  32'(mem_req), 32'd1);
    chk("t1_addr_c2", mem_addr,     32'h0);
    step();
    chk("t1_addr_c3",  mem_addr,         32'h4);
    chk("t1_valid_c3", 32'(instr_valid), 32'd0);
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", 32'(instr_valid), 32'd1);
      chk("t1_pc",    instr_pc,         32'(4 * k));
      chk("t1_instr", instr,            data_of(32'(4 * k)));
      step();
    end

    // ---- Back-pressure: FIFO fills, request stops, reasserts after a pop ----
    instr_ready = 1'b0;
    do_reset();
    grants = 0;
    repeat (6) step();
    chk("t2_grants",  32'(grants),      32'd4);
    chk("t2_req_off", 32'(mem_req),     32'd0);
    chk("t2_valid",   32'(instr_valid), 32'd1);
    chk("t2_head",    instr_pc,         32'h0);
    step();
    chk("t2_grants2",  32'(grants),  32'd4);
    chk("t2_req_off2", 32'(mem_req), 32'd0);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t2_req_on", 32'(mem_req), 32'd1);
    chk("t2_addr10", mem_addr,     32'h10);
    chk("t2_head4",  instr_pc,     32'h4);
    step();
    step();
    chk("t2_req_full", 32'(mem_req), 32'd0);
    instr_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t2_drain_valid", 32'(instr_valid), 32'd1);
      chk("t2_drain_pc",    instr_pc,         32'(4 * k));
      step();
    end

    // ---- Redirect with two requests outstanding ----
    do_reset();
    gnt_en = 1'b1; auto_rsp = 1'b0; instr_ready = 1'b1;
    step();
    step();
    step();
    gnt_en = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("t3_addr",   mem_addr,         32'h100);
    chk("t3_req",    32'(mem_req),     32'd1);
    chk("t3_valid5", 32'(instr_valid), 32'd0);
    auto_rsp = 1'b1;
    step();
    chk("t3_valid6", 32'(instr_valid), 32'd0);
    step();
    chk("t3_valid7", 32'(instr_valid), 32'd0);
    gnt_en = 1'b1;
    step();
    chk("t3_valid8", 32'(instr_valid), 32'd0);
    step();
    chk("t3_valid9", 32'(instr_valid), 32'd1);
    chk("t3_pc",     instr_pc,         32'h100);
    chk("t3_instr",  instr,            data_of(32'h100));

    // ---- Reset mid-transaction, then redirect with same-cycle grant + response ----
    instr_ready = 1'b0;
    do_reset();
    chk("t4_rst_req",   32'(mem_req),     32'd0);
    chk("t4_rst_valid", 32'(instr_valid), 32'd0);
    chk("t4_rst_addr",  mem_addr,         32'h0);
    gnt_en = 1'b1; auto_rsp = 1'b1;
    step();
    step();
    step();
    chk("t4_pre_valid", 32'(instr_valid), 32'd1);
    chk("t4_pre_addr",  mem_addr,         32'h8);
    redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk("t4_flushed", 32'(instr_valid), 32'd0);
    chk("t4_addr",    mem_addr,         32'h200);
    step();
    chk("t4_drop", 32'(instr_valid), 32'd0);
    step();
    chk("t4_valid", 32'(instr_valid), 32'd1);
    chk("t4_pc",    instr_pc,         32'h200);
    chk("t4_instr", instr,            data_of(32'h200));
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("t4_pc2",    instr_pc, 32'h204);
    chk("t4_instr2", instr,    data_of(32'h204));

    // ---- Address hold without grant, then wrap past 0xFFFF_FFFC ----
    do_reset();
    gnt_en = 1'b0; auto_rsp = 1'b1; instr_ready = 1'b1;
    step();
    chk("t5_req",  32'(mem_req), 32'd1);
    chk("t5_addr", mem_addr,     32'h0);
    step();
    chk("t5_hold", mem_addr, 32'h0);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect = 1'b0;
    chk("t5_addr_f8", mem_addr, 32'hFFFF_FFF8);
    gnt_en = 1'b1;
    step();
    chk("t5_addr_fc", mem_addr, 32'hFFFF_FFFC);
    step();
    chk("t5_addr_wrap", mem_addr, 32'h0);
    chk("t5_pc_f8",     instr_pc, 32'hFFFF_FFF8);
    step();
    chk("t5_pc_fc", instr_pc, 32'hFFFF_FFFC);
    step();
    chk("t5_pc_0",    instr_pc, 32'h0);
    chk("t5_instr_0", instr,    data_of(32'h0));

`ifdef FETCH_MISALIGN_CHK_EN
    // ---- Misaligned redirect ----
    do_reset();
    chk("t6_err_rst", 32'(misalign_err), 32'd0);
    gnt_en = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h102;
    step();
    redirect = 1'b0;
    chk("t6_err",  32'(misalign_err), 32'd1);
    chk("t6_req0", 32'(mem_req),      32'd0);
    gnt_en = 1'b1;
    repeat (3) step();
    chk("t6_err_sticky", 32'(misalign_err), 32'd1);
    chk("t6_req_stays0", 32'(mem_req),      32'd0);
    do_reset();
    chk("t6_err_clear", 32'(misalign_err), 32'd0);
    step();
    chk("t6_req_back", 32'(mem_req), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction prefetch stage sitting between the instruction memory port and the multicycle core's instruction register load.
- Issues sequential word fetches to memory and buffers responses in a DEPTH-entry FIFO together with their PC.
- Presents instruction words to the core with a valid/ready handshake.
- Supports a redirect (branch/jump/trap) that flushes buffered and in-flight fetches.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2; also the maximum number of outstanding memory requests.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- mem_req  output  1  fetch request valid
- mem_addr  output  32  fetch word address (bits [1:0] always 0 in normal operation)
- mem_gnt  input  1  memory accepts the request this cycle
- mem_rvalid  input  1  response data valid
- mem_rdata  input  32  response instruction word
- instr_valid  output  1  FIFO head holds a valid instruction
- instr  output  32  head instruction word
- instr_pc  output  32  PC of head instruction
- instr_ready  input  1  core consumes head this cycle
- redirect  input  1  flush and restart fetch
- redirect_pc  input  32  new fetch address
- misalign_err  output  1  misaligned redirect flag; exists only with FETCH_MISALIGN_CHK_EN

Behaviour:
- Reset: mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, FIFO empty, outstanding=0, discard=0, state=IDLE. Reset overrides every other input, including a reset asserted mid-transaction.
- FSM:
  - IDLE: the first cycle after reset, with no request. Goes to RUN unconditionally.
  - RUN: normal operation.
  - FLUSH: entered on redirect while discard>0. Returns to RUN when discard reaches 0.
  - Requests may issue in both RUN and FLUSH.
- Issue rule: mem_req=1 iff state!=IDLE and (fifo_count + outstanding) < DEPTH. This reserves a FIFO slot per request, so the FIFO never overflows.
- Address rules:
  - mem_addr holds stable while mem_req=1 and mem_gnt=0.
  - On mem_req & mem_gnt: fetch_pc += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) and outstanding += 1.
- Memory protocol: responses arrive in order, one per grant, at least 1 cycle after the grant.
  - On mem_rvalid: outstanding -= 1.
  - If discard>0: discard -= 1 and the data is dropped.
  - Otherwise: push {mem_rdata, resp_pc} and resp_pc += 4.
- FIFO latency: a pushed word is visible on instr_valid/instr the next cycle. There is no combinational bypass.
  - instr_valid = (count != 0).
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (takes priority over pop and push in the same cycle):
  - FIFO cleared; any same-cycle pop or response push is ignored.
  - fetch_pc = resp_pc = redirect_pc.
  - discard = outstanding-after-this-cycle: includes a grant in the redirect cycle, excludes a response arriving in it.
  - An ungranted pending request is abandoned. mem_addr switches to redirect_pc the cycle after redirect, and mem_req may stay high.
  - Back-to-back redirects: each recomputes discard from the current outstanding count.
- Counters: count and outstanding are log2(DEPTH)+1 bits wide. A response with outstanding=0 is a protocol error and is ignored (assertion in simulation).

Optional Feature:
- Macro: FETCH_MISALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err=1 (sticky until reset).
  - The flush still occurs, but no new requests issue while misalign_err=1.
- Undefined:
  - The misalign_err port is absent.
  - redirect_pc[1:0] are forced to 0 internally.

Test Plan:
- Reset, then free-running memory with gnt=1 and a 1-cycle rvalid latency, instr_ready=1 → first mem_req in cycle 2 at 0x0; instr_valid with instr_pc 0x0, 0x4, 0x8 … on consecutive cycles; data matches memory.
- instr_ready=0, DEPTH=4 → exactly 4 grants then mem_req=0; count=4; after one pop, mem_req reasserts for 0x10.
- Two requests outstanding, redirect to 0x100 → both late responses dropped; the next instr_pc is 0x100; no stale word is ever valid.
- Redirect in the same cycle as mem_gnt and mem_rvalid → discard=correct outstanding count; the FIFO ends empty; the new stream starts at redirect_pc.
- redirect_pc=0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 in order.
- With FETCH_MISALIGN_CHK_EN, redirect_pc=0x102 → misalign_err=1 next cycle; mem_req stays 0 until reset.
